// File: rtl/change_dispenser_if.sv
// Vend-event, handshake and status bundle between the vending front end and the payout controller.
// The controller takes the slave side; the vending FSM / hopper model takes the master side.
interface change_dispenser_if;
  logic       soda_i;
  logic [2:0] change_i;
  logic       soda_req_o;
  logic       soda_ack_i;
  logic       dime_req_o;
  logic       nickle_req_o;
  logic       coin_ack_i;
  logic [2:0] paid_o;
  logic       done_o;
  logic       busy_o;
  logic       full_o;
  logic       overflow_o;
  logic       fault_o;

  modport master (
    output soda_i, change_i, soda_ack_i, coin_ack_i,
    input  soda_req_o, dime_req_o, nickle_req_o, paid_o, done_o,
           busy_o, full_o, overflow_o, fault_o
  );

  modport slave (
    input  soda_i, change_i, soda_ack_i, coin_ack_i,
    output soda_req_o, dime_req_o, nickle_req_o, paid_o, done_o,
           busy_o, full_o, overflow_o, fault_o
  );
endinterface

// File: rtl/change_dispenser.sv
// Payout controller: queues vend events, drives the soda motor, then pays change dimes-first
// through request/ack handshakes with a per-request timeout that latches a fault.
module change_dispenser #(
  parameter int FIFO_DEPTH  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input logic               clk_i,
  input logic               rst_ni,
  change_dispenser_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SODA,
    S_DIME,
    S_NICKLE,
    S_GAP,
    S_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      remain_q, remain_d;
  logic [2:0]      paid_q, paid_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            done_q, done_d;
  logic            soda_req_q, dime_req_q, nickle_req_q;
  logic            busy_q, full_q, overflow_q, fault_q;

  logic [2:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [FIFO_DEPTH-1:0] wen;

  logic fifo_full, fifo_empty, push, pop, drop, in_req, tmo_expired;

  // Full is judged on start-of-cycle occupancy, so a same-cycle pop cannot rescue a push.
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = bus.soda_i && !fifo_full && (state_q != S_FAULT);
  assign drop       = bus.soda_i &&  fifo_full && (state_q != S_FAULT);
  // The done cycle is a settle cycle: the next queued event is popped one cycle later.
  assign pop        = (state_q == S_IDLE) && !fifo_empty && !done_q;

  assign in_req      = (state_q == S_SODA) || (state_q == S_DIME) || (state_q == S_NICKLE);
  assign tmo_expired = (tmo_q == TW'(ACK_TIMEOUT - 1));

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wen
      assign wen[gi] = push && (wr_ptr_q == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wen[i]) mem_q[i] <= bus.change_i;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  function automatic state_e select_next(input logic [2:0] r);
    if (r >= 3'd2)      return S_DIME;
    else if (r == 3'd1) return S_NICKLE;
    else                return S_IDLE;
  endfunction

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    paid_d   = paid_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          remain_d = mem_q[rd_ptr_q];
          paid_d   = '0;
          state_d  = S_SODA;
        end
      end
      S_SODA: begin
        if (bus.soda_ack_i)   state_d = select_next(remain_q);
        else if (tmo_expired) state_d = S_FAULT;
      end
      S_DIME: begin
        if (bus.coin_ack_i) begin
          remain_d = remain_q - 3'd2;
          paid_d   = paid_q + 3'd2;
          state_d  = S_GAP;
        end else if (tmo_expired) begin
          state_d = S_FAULT;
        end
      end
      S_NICKLE: begin
        if (bus.coin_ack_i) begin
          remain_d = remain_q - 3'd1;
          paid_d   = paid_q + 3'd1;
          state_d  = S_GAP;
        end else if (tmo_expired) begin
          state_d = S_FAULT;
        end
      end
      S_GAP:   state_d = select_next(remain_q);
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Request states never follow themselves directly, so staying put means still waiting.
  assign tmo_d  = (in_req && (state_d == state_q)) ? (tmo_q + TW'(1)) : '0;
  assign done_d = ((state_q == S_SODA) || (state_q == S_GAP)) && (state_d == S_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      remain_q     <= '0;
      paid_q       <= '0;
      tmo_q        <= '0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      soda_req_q   <= 1'b0;
      dime_req_q   <= 1'b0;
      nickle_req_q <= 1'b0;
      busy_q       <= 1'b0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      paid_q       <= paid_d;
      tmo_q        <= tmo_d;
      done_q       <= done_d;
      count_q      <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      soda_req_q   <= (state_d == S_SODA);
      dime_req_q   <= (state_d == S_DIME);
      nickle_req_q <= (state_d == S_NICKLE);
      busy_q       <= (state_d != S_IDLE) || (count_d != '0);
      full_q       <= (count_d == CW'(FIFO_DEPTH));
      overflow_q   <= overflow_q | drop;
      fault_q      <= (state_d == S_FAULT);
    end
  end

  assign bus.soda_req_o   = soda_req_q;
  assign bus.dime_req_o   = dime_req_q;
  assign bus.nickle_req_o = nickle_req_q;
  assign bus.paid_o       = paid_q;
  assign bus.done_o       = done_q;
  assign bus.busy_o       = busy_q;
  assign bus.full_o       = full_q;
  assign bus.overflow_o   = overflow_q;
  assign bus.fault_o      = fault_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout sequences, queueing/overflow, ack timeout,
// ack filtering and mid-payout reset, all against hand-computed expectations.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  change_dispenser_if bus();

  change_dispenser #(
    .FIFO_DEPTH (2),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.soda_req_o;
      1:       return bus.dime_req_o;
      2:       return bus.nickle_req_o;
      default: return bus.done_o;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output bit ok, output int waited);
    waited = 0;
    while (!sig(which) && waited < budget) begin
      tick();
      waited++;
    end
    ok = sig(which);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_soda_req"}, bus.soda_req_o, 0);
    chk({tag, "_dime_req"}, bus.dime_req_o, 0);
    chk({tag, "_nickle_req"}, bus.nickle_req_o, 0);
    chk({tag, "_paid"}, bus.paid_o, 0);
    chk({tag, "_done"}, bus.done_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_full"}, bus.full_o, 0);
    chk({tag, "_overflow"}, bus.overflow_o, 0);
    chk({tag, "_fault"}, bus.fault_o, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.soda_i = 1'b0;
    bus.change_i = 3'd0;
    bus.soda_ack_i = 1'b0;
    bus.coin_ack_i = 1'b0;
    tick();
    chk_all_zero(tag);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic vend(input logic [2:0] chg);
    bus.soda_i = 1'b1;
    bus.change_i = chg;
    tick();
    bus.soda_i = 1'b0;
  endtask

  task automatic ack_coin();
    tick();
    bus.coin_ack_i = 1'b1;
    tick();
    bus.coin_ack_i = 1'b0;
  endtask

  // Serves one transaction, acking each request one cycle after it rises.
  task automatic serve(input logic [2:0] chg, input int soda_wait);
    bit ok;
    int w;
    int n_dimes;
    n_dimes = int'(chg) / 2;
    wait_sig(0, 20, ok, w);
    chk("soda_req", ok, 1);
    if (soda_wait >= 0) chk("soda_latency", w, soda_wait);
    tick();
    bus.soda_ack_i = 1'b1;
    tick();
    bus.soda_ack_i = 1'b0;
    chk("soda_req_drop", bus.soda_req_o, 0);
    for (int i = 0; i < n_dimes; i++) begin
      wait_sig(1, 5, ok, w);
      chk("dime_req", ok, 1);
      chk("dime_gap", w, (i == 0) ? 0 : 1);
      chk("dime_not_nickle", bus.nickle_req_o, 0);
      ack_coin();
      chk("dime_drop", bus.dime_req_o, 0);
    end
    if (chg[0]) begin
      wait_sig(2, 5, ok, w);
      chk("nickle_req", ok, 1);
      chk("nickle_gap", w, (n_dimes == 0) ? 0 : 1);
      chk("nickle_not_dime", bus.dime_req_o, 0);
      ack_coin();
      chk("nickle_drop", bus.nickle_req_o, 0);
    end
    wait_sig(3, 5, ok, w);
    chk("done", ok, 1);
    chk("done_latency", w, (chg == 3'd0) ? 0 : 1);
    chk("paid", bus.paid_o, chg);
    chk("coin_idle_at_done", bus.dime_req_o | bus.nickle_req_o, 0);
    $display("txn change=%0d paid=%0d", chg, bus.paid_o);
    tick();
    chk("done_single_pulse", bus.done_o, 0);
  endtask

  initial begin
    bit ok;
    int w;
    int n;
    rst_n = 1'b0;
    bus.soda_i = 1'b0;
    bus.change_i = 3'd0;
    bus.soda_ack_i = 1'b0;
    bus.coin_ack_i = 1'b0;

    // Change 7: soda, dime x3, nickel.
    do_reset("rst0");
    vend(3'd7);
    chk("busy_after_vend", bus.busy_o, 1);
    serve(3'd7, 1);
    chk("busy_after_txn7", bus.busy_o, 0);

    // Change 0: soda only.
    do_reset("rst1");
    vend(3'd0);
    serve(3'd0, 1);
    chk("busy_after_txn0", bus.busy_o, 0);

    // Queue three events, fourth is dropped.
    do_reset("rst2");
    vend(3'd3);
    vend(3'd1);
    vend(3'd4);
    chk("full_at_depth", bus.full_o, 1);
    chk("no_overflow_yet", bus.overflow_o, 0);
    chk("soda_req_held", bus.soda_req_o, 1);
    vend(3'd5);
    chk("overflow_set", bus.overflow_o, 1);
    chk("full_still", bus.full_o, 1);
    serve(3'd3, 0);
    serve(3'd1, 1);
    serve(3'd4, 1);
    tick();
    tick();
    chk("busy_drained", bus.busy_o, 0);
    chk("full_drained", bus.full_o, 0);
    chk("overflow_sticky", bus.overflow_o, 1);
    chk("no_fourth_txn", bus.soda_req_o, 0);

    // Dime never acked: timeout into FAULT.
    do_reset("rst3");
    vend(3'd2);
    wait_sig(0, 20, ok, w);
    chk("to_soda_req", ok, 1);
    tick();
    bus.soda_ack_i = 1'b1;
    tick();
    bus.soda_ack_i = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && bus.dime_req_o; i++) begin
      n++;
      tick();
    end
    chk("dime_hold_cycles", n, 15);
    chk("fault_set", bus.fault_o, 1);
    chk("fault_busy", bus.busy_o, 1);
    vend(3'd1);
    vend(3'd2);
    vend(3'd3);
    tick();
    chk("fault_no_push", bus.full_o, 0);
    chk("fault_no_overflow", bus.overflow_o, 0);
    chk("fault_no_req", bus.soda_req_o | bus.dime_req_o | bus.nickle_req_o, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("fault_sticky", bus.fault_o, 1);
    do_reset("rst_fault");

    // Spurious coin acks in SODA and GAP, then reset mid-payout.
    vend(3'd3);
    wait_sig(0, 20, ok, w);
    chk("sp_soda_req", ok, 1);
    bus.coin_ack_i = 1'b1;
    tick();
    bus.coin_ack_i = 1'b0;
    bus.soda_ack_i = 1'b1;
    tick();
    bus.soda_ack_i = 1'b0;
    chk("sp_dime_req", bus.dime_req_o, 1);
    chk("sp_paid_after_soda", bus.paid_o, 0);
    tick();
    bus.coin_ack_i = 1'b1;
    tick();
    chk("sp_paid_after_dime", bus.paid_o, 2);
    chk("sp_gap_no_req", bus.dime_req_o | bus.nickle_req_o, 0);
    tick();
    bus.coin_ack_i = 1'b0;
    chk("sp_nickle_req", bus.nickle_req_o, 1);
    chk("sp_paid_after_gap", bus.paid_o, 2);
    do_reset("rst_mid");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Back-end payout controller for the vending machine. Consumes the one-cycle vend events (`soda` + `change` code, in nickel units) produced by the vending FSM and queues them. It then drives the soda motor and a two-chute coin hopper (dime, nickel) through request/acknowledge handshakes, paying change greedily with dimes first. It has a small event FIFO, per-request ack timeout with sticky fault, and status flags.

## Interface
- `FIFO_DEPTH`, default 2: number of queued vend events (power of two, ≥2).
- `ACK_TIMEOUT`, default 15: maximum number of cycles a request may stay high without an ack (≥2).

Ports:
- `clk_i` in 1: clock. Single clock domain; all state changes on its rising edge.
- `rst_ni` in 1: synchronous, active-low reset.
- `soda_i` in 1: vend event, one-cycle pulse.
- `change_i` in 3: change owed in nickels (0–7). Sampled only when `soda_i`=1.
- `soda_req_o` out 1: dispense-soda request.
- `soda_ack_i` in 1: soda motor done.
- `dime_req_o` out 1: eject one dime.
- `nickle_req_o` out 1: eject one nickel.
- `coin_ack_i` in 1: hopper ejected the currently requested coin.
- `paid_o` out 3: nickels paid so far in the current or last transaction.
- `done_o` out 1: one-cycle pulse when a transaction completes.
- `busy_o` out 1: FSM not in IDLE, or FIFO non-empty.
- `full_o` out 1: FIFO count equals `FIFO_DEPTH`.
- `overflow_o` out 1: sticky; a vend event was dropped.
- `fault_o` out 1: sticky; an ack timeout occurred.

## Operation
- **Reset** (`rst_ni`=0 at a clock edge): FSM goes to IDLE, FIFO is emptied, remaining-change and timeout counters clear. Every output is 0.
- **Push**: when `soda_i`=1 and `full_o`=0, write `change_i` into the FIFO.
  - If `full_o`=1, drop the event and set `overflow_o`. This holds even if a pop occurs in the same cycle, because `full_o` is evaluated from start-of-cycle state.
  - In FAULT, pushes are ignored and `overflow_o` is not set.
- **Pop**: only in IDLE, and only when the FIFO held an entry at the start of the cycle.
  - A pop loads `remain` (3-bit) from the entry and clears `paid_o`. The next state is SODA.
  - A simultaneous push and pop leaves the count unchanged.
- **States**:
  - IDLE: all requests low.
  - SODA: `soda_req_o`=1 until `soda_ack_i`=1. On the ack cycle, apply the select rule.
  - DIME: `dime_req_o`=1 until `coin_ack_i`=1. On the ack cycle, `remain` −= 2 and `paid_o` += 2; go to GAP.
  - NICKLE: `nickle_req_o`=1 until `coin_ack_i`=1. On the ack cycle, `remain` −= 1 and `paid_o` += 1; go to GAP.
  - GAP: one cycle with all requests low, then apply the select rule.
  - FAULT: all requests low and `fault_o`=1. Exit only by reset.
- **Select rule**:
  - `remain` ≥ 2 → DIME.
  - `remain` = 1 → NICKLE.
  - `remain` = 0 → IDLE, and pulse `done_o` on that transition.
- **Ack filtering**: acks are honoured only in the matching state. `coin_ack_i` in SODA/IDLE/GAP and `soda_ack_i` outside SODA are ignored.
- **Timeout**: the counter clears on entry to SODA/DIME/NICKLE and increments each cycle without the matching ack. When it reaches `ACK_TIMEOUT`, the next state is FAULT and `fault_o` is set. An ack on that same cycle takes precedence over the timeout.
- **Payout arithmetic**: a transaction pays floor(change/2) dimes, then change mod 2 nickels. Final `paid_o` equals `change_i`, and `remain` never underflows.

## Timing
- Latency from vend event to soda request: `soda_i` at cycle 0 (FIFO empty, IDLE) → pop at cycle 1 → `soda_req_o` high from cycle 2.
- Each request drops in the cycle after its ack. Next coin request comes at ack+2, because of the GAP cycle.
- `done_o` is high in the cycle after the final ack, or after the GAP cycle that selects IDLE. For change=0 it is high the cycle after `soda_ack_i`.
- A back-to-back queued event starts SODA 2 cycles after `done_o`.
- The longest a request is held high is `ACK_TIMEOUT` cycles.
- Reset mid-transaction: all outputs are 0 in the next cycle and the queued events are lost.

## Test plan
- Reset, then `soda_i`=1 with change=7. Ack each request 1 cycle after it rises. Expected sequence: soda, dime, dime, dime, nickel. Expected `paid_o`=7 and one `done_o` pulse.
- Change=0: only `soda_req_o` asserts (from cycle 2). `done_o` pulses the cycle after ack; no coin requests.
- Three vend events (change 3, 1, 4) on consecutive cycles while `soda_ack_i` is held low. First event is popped into SODA; events 2 and 3 fill the FIFO; `full_o`=1, no drop, `overflow_o` stays 0. A fourth event is dropped and sets `overflow_o`. Releasing acks pays 3, 1, 4 in order.
- Hold `coin_ack_i` low in DIME. `dime_req_o` stays high for exactly 15 cycles, then FAULT with `fault_o`=1. Later events are ignored. Only `rst_ni`=0 clears the fault.
- Spurious `coin_ack_i` during SODA and GAP has no effect on `remain`/`paid_o`. Assert `rst_ni`=0 mid-payout: all outputs 0 the next cycle and `busy_o`=0.
